lease_victim_select: RTL
========================

// Module: lease_victim_select
// PURPOSE
//   Tracks which cache lines hold an expired lease and picks a replacement victim on request.
//   Drives the 1024-bit expired-line vector into the multi-detect priority encoder and registers
//   that encoder's bin/vld/multi_detect result; with no expired line, falls back to an LFSR index.
//   Sits between lease-counter update logic / fill path and the cache replacement controller.
// PARAMETERS
//   N_LINES   1024  number of cache lines (power of 2, >=16); width of exp_vec
//   BW        10    log2(N_LINES); width of every line index
// PORTS
//   clk          in   1        clock; all state updates on rising edge
//   rst          in   1        asynchronous, active-low reset
//   exp_set      in   1        pulse: mark line exp_set_idx expired
//   exp_set_idx  in   BW       line index for exp_set
//   fill_clr     in   1        pulse: line fill_clr_idx refilled; clear its expired bit
//   fill_clr_idx in   BW       line index for fill_clr
//   exp_vec      out  N_LINES  registered expired-line vector, to encoder oht
//   pe_bin       in   BW       encoder index (combinational return from exp_vec)
//   pe_vld       in   1        encoder valid: at least one expired line
//   pe_multi     in   1        encoder multi_detect flag
//   req_valid    in   1        victim request
//   req_ready    out  1        high only in IDLE
//   rsp_valid    out  1        victim result valid
//   rsp_ready    in   1        consumer accepts result
//   rsp_idx      out  BW       victim line index
//   rsp_expired  out  1        1: victim came from exp_vec; 0: LFSR fallback
//   rsp_multi    out  1        registered pe_multi at sample time
// BEHAVIOUR
//   Reset (rst=0, async): exp_vec=0, state=IDLE, rsp_valid=0, rsp_idx=0, rsp_expired=0,
//     rsp_multi=0, lfsr=BW'h001. req_ready is 0 while rst=0 and 1 in IDLE after release.
//   exp_vec update, every cycle, per bit i. Priority (highest first):
//     1. rsp accept clear (rsp_valid & rsp_ready & rsp_expired & i==rsp_idx) -> 0
//     2. fill_clr & i==fill_clr_idx -> 0
//     3. exp_set & i==exp_set_idx -> 1
//     Set and clear on different indices in one cycle both take effect.
//   LFSR: Fibonacci, x^10+x^7+1 for BW=10 (maximal polynomial per BW held in the package).
//     Advances every cycle after reset; never reaches 0.
//   FSM:
//     IDLE  : req_ready=1; on req_valid -> SAMPLE.
//     SAMPLE: one cycle for the encoder to settle on the current exp_vec. Latch:
//             rsp_idx = pe_vld ? pe_bin : lfsr; rsp_expired = pe_vld; rsp_multi = pe_vld & pe_multi.
//             -> RESP.
//     RESP  : rsp_valid=1; rsp_* held stable until rsp_ready; on accept -> IDLE with rsp_valid=0
//             next cycle.
//   Latency: req accepted in cycle t -> rsp_valid in cycle t+2. Minimum spacing between
//     requests is 3 cycles.
//   Boundary cases:
//     - rsp_idx bit cleared by fill_clr during RESP: rsp_idx is unchanged; the accept clear is idempotent.
//     - exp_set on rsp_idx in the accept cycle: the clear wins.
//     - exp_vec all ones: pe_bin gives the encoder's priority index.
//     - rst asserted mid-transaction: everything returns to reset values immediately; the
//       outstanding response is dropped.
// CONFIGURATION
//   LEASE_VICTIM_STATS_EN defined: adds outputs stat_exp_cnt, stat_rand_cnt, stat_multi_cnt
//     (32 bits each, reset 0, saturating). They increment on each accepted response that is
//     expired / fallback / rsp_multi respectively.
//   Undefined: these ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//   Package lease_cache_pkg: N_LINES/BW defaults, FSM state enum {IDLE,SAMPLE,RESP},
//     LFSR tap constants per BW.
//   Sub-module lease_victim_lfsr (BW-wide LFSR, async active-low reset, seed 1).
//     The encoder stays external and connects via exp_vec / pe_*.
// TESTING (bench models the encoder as lowest-set-bit + multi flag)
//   1. Reset, exp_vec=0, req -> rsp at t+2: rsp_expired=0, rsp_idx = LFSR value at SAMPLE (nonzero).
//   2. exp_set idx 5, then req -> rsp_idx=5, rsp_expired=1, rsp_multi=0; after accept exp_vec[5]=0.
//   3. exp_set 8 and 9 -> rsp_idx=8, rsp_multi=1; after accept exp_vec has only bit 9 set.
//   4. Hold rsp_ready=0 for 10 cycles -> rsp_* stable; exp_set on rsp_idx in the accept cycle
//      -> bit ends 0.
//   5. Same-cycle fill_clr 3 and exp_set 3 -> exp_vec[3]=0; exp_set 1023 with fill_clr 0 -> both applied.
//   6. rst=0 during RESP -> rsp_valid=0 and exp_vec=0 asynchronously; a new req after release works.

Source files
------------

// File: rtl/lease_victim_select_pkg.sv
// Shared defaults, FSM state encoding and maximal-length LFSR taps for the lease victim selector.
// Purely declarative; no timing or backpressure of its own.
package lease_cache_pkg;

  localparam int N_LINES_DFLT = 1024;
  localparam int BW_DFLT      = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    RESP   = 2'd2
  } vs_state_e;

  // Fibonacci tap masks (bit k = term x^(k+1)); BW=10 is x^10 + x^7 + 1
  function automatic logic [31:0] lfsr_taps(input int bw);
    logic [31:0] taps;
    case (bw)
      4:       taps = 32'h0000_000C;
      5:       taps = 32'h0000_0014;
      6:       taps = 32'h0000_0030;
      7:       taps = 32'h0000_0060;
      8:       taps = 32'h0000_00B8;
      9:       taps = 32'h0000_0110;
      10:      taps = 32'h0000_0240;
      11:      taps = 32'h0000_0500;
      12:      taps = 32'h0000_0829;
      13:      taps = 32'h0000_100D;
      14:      taps = 32'h0000_2015;
      15:      taps = 32'h0000_6000;
      16:      taps = 32'h0000_D008;
      default: taps = 32'h0000_0240;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/lease_victim_select_if.sv
// Victim request/response handshake between the replacement controller (master) and the selector (slave).
// Request is a valid/ready pair; the response holds until the consumer raises rsp_ready.
interface lease_victim_select_if #(
  parameter int BW = 10
);
  logic          req_valid;
  logic          req_ready;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [BW-1:0] rsp_idx;
  logic          rsp_expired;
  logic          rsp_multi;

  modport master (
    output req_valid, rsp_ready,
    input  req_ready, rsp_valid, rsp_idx, rsp_expired, rsp_multi
  );

  modport slave (
    input  req_valid, rsp_ready,
    output req_ready, rsp_valid, rsp_idx, rsp_expired, rsp_multi
  );
endinterface

// File: rtl/lease_victim_select_lfsr.sv
// Free-running BW-bit Fibonacci LFSR seeded to 1; supplies the fallback victim index.
// Advances every cycle out of reset; no backpressure, never reaches zero.
module lease_victim_lfsr
  import lease_cache_pkg::*;
#(
  parameter int BW = BW_DFLT
) (
  input  logic          clk,
  input  logic          rst,
  output logic [BW-1:0] lfsr
);

  localparam logic [BW-1:0] TAPS = BW'(lfsr_taps(BW));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= BW'(1);
    end else begin
      lfsr <= {lfsr[BW-2:0], ^(lfsr & TAPS)};
    end
  end

endmodule

// File: rtl/lease_victim_select.sv
// Expired-lease tracker and victim picker (encoder external via exp_vec/pe_*); LEASE_VICTIM_STATS_EN adds counters.
// Latency: request accepted in cycle t -> rsp_valid in cycle t+2; one request in flight.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready.
module lease_victim_select
  import lease_cache_pkg::*;
#(
  parameter int N_LINES = N_LINES_DFLT,
  parameter int BW      = $clog2(N_LINES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exp_set,
  input  logic [BW-1:0]      exp_set_idx,
  input  logic               fill_clr,
  input  logic [BW-1:0]      fill_clr_idx,
  output logic [N_LINES-1:0] exp_vec,
  input  logic [BW-1:0]      pe_bin,
  input  logic               pe_vld,
  input  logic               pe_multi,
  lease_victim_select_if.slave vs
`ifdef LEASE_VICTIM_STATS_EN
  ,
  output logic [31:0]        stat_exp_cnt,
  output logic [31:0]        stat_rand_cnt,
  output logic [31:0]        stat_multi_cnt
`endif
);

  vs_state_e          state, state_nxt;
  logic [BW-1:0]      lfsr;
  logic [N_LINES-1:0] exp_nxt;
  logic               accept;

  lease_victim_lfsr #(.BW(BW)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

  assign accept = vs.rsp_valid & vs.rsp_ready;

  always_comb begin
    state_nxt    = state;
    vs.req_ready = 1'b0;
    vs.rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        // Gated by rst so the controller never sees ready while the block is held in reset
        vs.req_ready = rst;
        if (vs.req_valid) state_nxt = SAMPLE;
      end
      SAMPLE: state_nxt = RESP;
      RESP: begin
        vs.rsp_valid = 1'b1;
        if (vs.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs.rsp_idx     <= '0;
      vs.rsp_expired <= 1'b0;
      vs.rsp_multi   <= 1'b0;
    end else if (state == SAMPLE) begin
      vs.rsp_idx     <= pe_vld ? pe_bin : lfsr;
      vs.rsp_expired <= pe_vld;
      vs.rsp_multi   <= pe_vld & pe_multi;
    end
  end

  // Later writes win: accept-clear over fill clear over new expiry
  always_comb begin
    exp_nxt = exp_vec;
    if (exp_set)                  exp_nxt[exp_set_idx]  = 1'b1;
    if (fill_clr)                 exp_nxt[fill_clr_idx] = 1'b0;
    if (accept && vs.rsp_expired) exp_nxt[vs.rsp_idx]   = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) exp_vec <= '0;
    else      exp_vec <= exp_nxt;
  end

`ifdef LEASE_VICTIM_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_exp_cnt   <= '0;
      stat_rand_cnt  <= '0;
      stat_multi_cnt <= '0;
    end else if (accept) begin
      if (vs.rsp_expired && stat_exp_cnt != '1)    stat_exp_cnt   <= stat_exp_cnt + 32'd1;
      if (!vs.rsp_expired && stat_rand_cnt != '1)  stat_rand_cnt  <= stat_rand_cnt + 32'd1;
      if (vs.rsp_multi && stat_multi_cnt != '1)    stat_multi_cnt <= stat_multi_cnt + 32'd1;
    end
  end
`endif

endmodule
